// File: rtl/ride_event_logger.sv
// ride_event_logger: timestamped event log for the ride safety FSM.
// Every change of {state, fault_code} writes one entry
// {ts, old_state, new_state, fault_code, alarm} into a first-word-fall-through FIFO.
// Consumers drain the FIFO through a valid/ready read port. Sticky summary flags are
// also kept: shutdown seen, the first fault code and a saturating overflow count.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   state, alarm,       monitored FSM outputs
//   fault_code
//   clear               synchronous flush of the log and the sticky flags
//   rd_ready            consumer accepts the head entry
//   rd_valid, rd_data   head entry of the log (valid while the log is non-empty)
//   count               number of entries held
//   overflow_cnt        number of events dropped while full (saturating)
//   shutdown_seen       sticky: state 3 observed
//   first_fault_valid/  sticky: fault code of the first event into FAULT/SHUTDOWN
//   first_fault_code
module ride_event_logger #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned OVF_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 state,
    input  logic                       alarm,
    input  logic [2:0]                 fault_code,
    input  logic                       clear,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [TS_W+7:0]            rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [OVF_W-1:0]           overflow_cnt,
    output logic                       shutdown_seen,
    output logic                       first_fault_valid,
    output logic [2:0]                 first_fault_code
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned EntW = TS_W + 8;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [1:0]       prev_state_q, prev_state_d;
    logic [2:0]       prev_fault_q, prev_fault_d;
    logic [EntW-1:0]  mem_q [DEPTH];
    logic [EntW-1:0]  mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             shut_q, shut_d;
    logic             ffv_q, ffv_d;
    logic [2:0]       ffc_q, ffc_d;

    logic            evt;
    logic            full;
    logic            pop;
    logic            push;
    logic [EntW-1:0] entry;

    assign evt   = {state, fault_code} != {prev_state_q, prev_fault_q};
    assign full  = (count_q == CntW'(DEPTH));
    assign pop   = (count_q != '0) && rd_ready;
    // A full log still accepts a write when the head leaves on the same edge.
    assign push  = evt && (!full || pop);
    assign entry = {ts_q, prev_state_q, state, fault_code, alarm};

    always_comb begin
        ts_d         = ts_q + TS_W'(1);
        // prev_* tracks the inputs every edge, including during clear.
        prev_state_d = state;
        prev_fault_d = fault_code;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        shut_d       = shut_q;
        ffv_d        = ffv_q;
        ffc_d        = ffc_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = '0;
            shut_d   = 1'b0;
            ffv_d    = 1'b0;
            ffc_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = entry;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
            if (evt && full && !pop && (ovf_q != '1)) begin
                ovf_d = ovf_q + OVF_W'(1);
            end
            if (state == 2'd3) begin
                shut_d = 1'b1;
            end
            if (evt && state[1] && !ffv_q) begin
                ffv_d = 1'b1;
                ffc_d = fault_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q         <= '0;
            prev_state_q <= '0;
            prev_fault_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= '0;
            shut_q       <= 1'b0;
            ffv_q        <= 1'b0;
            ffc_q        <= '0;
        end else begin
            ts_q         <= ts_d;
            prev_state_q <= prev_state_d;
            prev_fault_q <= prev_fault_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            shut_q       <= shut_d;
            ffv_q        <= ffv_d;
            ffc_q        <= ffc_d;
        end
    end

    assign rd_valid          = (count_q != '0);
    assign rd_data           = mem_q[rd_ptr_q];
    assign count             = count_q;
    assign overflow_cnt      = ovf_q;
    assign shutdown_seen     = shut_q;
    assign first_fault_valid = ffv_q;
    assign first_fault_code  = ffc_q;

endmodule

// File: tb/tb_ride_event_logger.sv
// Bench for ride_event_logger: directed stimulus pushes expected log entries into a
// scoreboard queue; a monitor pops and compares whenever an entry is consumed.
module tb_ride_event_logger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  state = 2'd0;
    logic        alarm = 1'b0;
    logic [2:0]  fault_code = 3'd0;
    logic        clear = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [3:0]  count;
    logic [7:0]  overflow_cnt;
    logic        shutdown_seen;
    logic        first_fault_valid;
    logic [2:0]  first_fault_code;

    int total = 0;
    int bad = 0;

    logic [23:0] sb[$];
    logic [15:0] tb_ts;
    logic [1:0]  m_state;
    logic [2:0]  m_fault;

    ride_event_logger #(
        .DEPTH(8),
        .TS_W (16),
        .OVF_W(8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .state            (state),
        .alarm            (alarm),
        .fault_code       (fault_code),
        .clear            (clear),
        .rd_ready         (rd_ready),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .count            (count),
        .overflow_cnt     (overflow_cnt),
        .shutdown_seen    (shutdown_seen),
        .first_fault_valid(first_fault_valid),
        .first_fault_code (first_fault_code)
    );

    always #5 clk = ~clk;

    // Expected timestamp: cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 16'd0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an entry is consumed at the next edge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready && !clear) begin
            if (sb.size() == 0) begin
                chk("unexpected_entry", {8'd0, rd_data}, 32'hffffffff);
            end else begin
                chk("entry", {8'd0, rd_data}, {8'd0, sb.pop_front()});
            end
        end
    end

    // One clock cycle with the given inputs; exp_push says whether an entry should land.
    task automatic cyc(input logic [1:0] s, input logic [2:0] f, input logic a,
                       input logic r, input logic c, input bit exp_push);
        state      = s;
        fault_code = f;
        alarm      = a;
        rd_ready   = r;
        clear      = c;
        if (c) sb.delete();
        if (exp_push) sb.push_back({tb_ts, m_state, s, f, a});
        m_state = s;
        m_fault = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        sb.delete();
        m_state = 2'd0;
        m_fault = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        m_state = 2'd0;
        m_fault = 3'd0;

        // Reset held with state=2 on the inputs.
        state      = 2'd2;
        fault_code = 3'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_data", {8'd0, rd_data}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_ovf", {24'd0, overflow_cnt}, 32'd0);
        chk("rst_flags", {29'd0, shutdown_seen, first_fault_valid, 1'b0}, 32'd0);
        rst_n = 1'b1;
        cyc(2'd2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("first_evt_count", {28'd0, count}, 32'd1);
        chk("first_evt_data", {8'd0, rd_data}, {8'd0, 16'd0, 2'd0, 2'd2, 3'd5, 1'b1});
        chk("ffv_after_rst", {31'd0, first_fault_valid}, 32'd1);
        chk("ffc_after_rst", {29'd0, first_fault_code}, 32'd5);
        cyc(2'd2, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("drain1_count", {28'd0, count}, 32'd0);

        // Back to NORMAL, then a single transition exactly at ts=10.
        cyc(2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (tb_ts != 16'd10 && n < 50) begin
            cyc(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        cyc(2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("single_valid", {31'd0, rd_valid}, 32'd1);
        chk("single_data", {8'd0, rd_data}, {8'd0, 16'd10, 2'd0, 2'd1, 3'd0, 1'b0});
        // Alarm alone is not an event.
        cyc(2'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("alarm_only", {28'd0, count}, 32'd1);
        cyc(2'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("single_drain", {28'd0, count}, 32'd0);
        cyc(2'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ready_empty", {28'd0, count}, 32'd0);

        // Ten transitions with no consumer: first 8 stored, last 2 dropped.
        for (int i = 1; i <= 10; i++) begin
            logic [2:0] f;
            f = 3'(i);
            cyc(2'd1, f, i[0], 1'b0, 1'b0, i <= 8);
        end
        chk("ovf_count", {28'd0, count}, 32'd8);
        chk("ovf_cnt", {24'd0, overflow_cnt}, 32'd2);

        // Full with a simultaneous pop and event: no drop.
        cyc(2'd1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("fullpop_count", {28'd0, count}, 32'd8);
        chk("fullpop_ovf", {24'd0, overflow_cnt}, 32'd2);
        repeat (8) cyc(2'd1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("drain_all", {28'd0, count}, 32'd0);
        chk("sb_empty1", 32'(sb.size()), 32'd0);

        // Sticky flags.
        cyc(2'd1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_ffv", {31'd0, first_fault_valid}, 32'd0);
        chk("clr_ovf", {24'd0, overflow_cnt}, 32'd0);
        cyc(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(2'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(2'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(2'd3, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sticky_ffv", {31'd0, first_fault_valid}, 32'd1);
        chk("sticky_ffc", {29'd0, first_fault_code}, 32'd3);
        chk("sticky_shut", {31'd0, shutdown_seen}, 32'd1);
        chk("sticky_count", {28'd0, count}, 32'd4);

        // Clear coincident with an event: nothing logged, ts keeps running.
        cyc(2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_count", {28'd0, count}, 32'd0);
        chk("clr_valid", {31'd0, rd_valid}, 32'd0);
        chk("clr_sticky", {29'd0, shutdown_seen, first_fault_valid, 1'b0}, 32'd0);
        chk("clr_ffc", {29'd0, first_fault_code}, 32'd0);
        cyc(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("no_spurious", {28'd0, count}, 32'd0);
        cyc(2'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_clr_ts", {16'd0, rd_data[23:8]}, {16'd0, tb_ts - 16'd1});
        cyc(2'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);

        // Async reset mid-burst with five entries held.
        for (int i = 0; i < 5; i++) begin
            logic [2:0] f;
            f = 3'(i + 4);
            cyc(2'd0, f, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("burst_count", {28'd0, count}, 32'd5);
        #2;
        do_reset();
        #1;
        chk("async_count", {28'd0, count}, 32'd0);
        chk("async_valid", {31'd0, rd_valid}, 32'd0);
        chk("async_data", {8'd0, rd_data}, 32'd0);
        state      = 2'd0;
        fault_code = 3'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("zero_no_event", {28'd0, count}, 32'd0);
        // shutdown_seen follows state==3 even when it is already logged state.
        cyc(2'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("shut_again", {31'd0, shutdown_seen}, 32'd1);
        cyc(2'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sb_empty2", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
